// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller, the memory port and the datapath.
interface multicycle_ctrl_if #(
   parameter int RETIRE_W = 32
);
   logic [31:0]         instr_i;
   logic                mem_ready_i;
   logic                branch_taken_i;
   logic                mem_req_o;
   logic                mem_we_o;
   logic                iord_o;
   logic                ir_we_o;
   logic                pc_we_o;
   logic [1:0]          pc_src_o;
   logic                reg_we_o;
   logic [1:0]          wb_sel_o;
   logic [3:0]          alu_op_o;
   logic [1:0]          shift_o;
   logic                illegal_o;
   logic [2:0]          state_o;
   logic [RETIRE_W-1:0] retired_o;

   // Controller side
   modport master (
      input  instr_i, mem_ready_i, branch_taken_i,
      output mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o,
             reg_we_o, wb_sel_o, alu_op_o, shift_o, illegal_o, state_o, retired_o
   );

   // Datapath / memory side
   modport slave (
      output instr_i, mem_ready_i, branch_taken_i,
      input  mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o,
             reg_we_o, wb_sel_o, alu_op_o, shift_o, illegal_o, state_o, retired_o
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Strobes depend only on registered state, the latched decode fields and the
// memory/branch handshake inputs; instr_i only feeds the DECODE latch and the
// next-state legality check, never a strobe.
module multicycle_ctrl #(
   parameter int RETIRE_W = 32
) (
   input logic               clk_i,
   input logic               rst_n_i,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [6:0] OP_R    = 7'h33;
   localparam logic [6:0] OP_I    = 7'h13;
   localparam logic [6:0] OP_LD   = 7'h03;
   localparam logic [6:0] OP_ST   = 7'h23;
   localparam logic [6:0] OP_BR   = 7'h63;
   localparam logic [6:0] OP_JAL  = 7'h6F;
   localparam logic [6:0] OP_JALR = 7'h67;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;

   state_t              state_r;
   logic [6:0]          opcode_r;
   logic [2:0]          funct3_r;
   logic [6:0]          funct7_r;
   logic                illegal_r;
   logic                rst_hold_r;   // first cycle after reset: FETCH with strobes quiet
   logic [RETIRE_W-1:0] retired_r;

   logic                retire_s;
   logic                mem_req_s, mem_we_s, iord_s, ir_we_s, pc_we_s, reg_we_s;
   logic [1:0]          pc_src_s, wb_sel_s, shift_s;
   logic [3:0]          alu_op_s;
   logic                unused_s;

   // Operand/immediate fields are consumed by the datapath, not here.
   assign unused_s = ^{bus.instr_i[24:15], bus.instr_i[11:7]};

   function automatic logic is_legal(input logic [31:0] instr);
      logic ok;
      ok = 1'b0;
      case (instr[6:0])
         OP_R: begin
            if (instr[31:25] == 7'h20) begin
               ok = 1'b1;
            end else if (instr[31:25] == 7'h00) begin
               ok = (instr[14:12] == 3'b000) || (instr[14:12] == 3'b111) ||
                    (instr[14:12] == 3'b110);
            end else begin
               ok = 1'b0;
            end
         end
         OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7);
      logic [3:0] alu;
      alu = ALU_ADD;
      case (op)
         OP_R: begin
            if (f7 == 7'h20) begin
               alu = ALU_SUB;
            end else begin
               case (f3)
                  3'b111:  alu = ALU_AND;
                  3'b110:  alu = ALU_OR;
                  default: alu = ALU_ADD;
               endcase
            end
         end
         OP_BR:   alu = ALU_SUB;
         default: alu = ALU_ADD;
      endcase
      return alu;
   endfunction

   function automatic logic [1:0] shift_decode(input logic [6:0] op, input logic [2:0] f3);
      logic [1:0] sh;
      sh = 2'b00;
      if (op == OP_I) begin
         case (f3)
            3'b001:  sh = 2'b11;
            3'b101:  sh = 2'b10;
            default: sh = 2'b00;
         endcase
      end else begin
         sh = 2'b00;
      end
      return sh;
   endfunction

   // State register, decode latch, illegal pulse and retirement counter.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_r    <= S_FETCH;
         opcode_r   <= 7'd0;
         funct3_r   <= 3'd0;
         funct7_r   <= 7'd0;
         illegal_r  <= 1'b0;
         rst_hold_r <= 1'b1;
         retired_r  <= '0;
      end else begin
         rst_hold_r <= 1'b0;
         illegal_r  <= 1'b0;
         if (retire_s) begin
            retired_r <= retired_r + {{(RETIRE_W-1){1'b0}}, 1'b1};
         end
         case (state_r)
            S_FETCH: begin
               if (!rst_hold_r && bus.mem_ready_i) begin
                  state_r <= S_DECODE;
               end
            end
            S_DECODE: begin
               opcode_r <= bus.instr_i[6:0];
               funct3_r <= bus.instr_i[14:12];
               funct7_r <= bus.instr_i[31:25];
               if (is_legal(bus.instr_i)) begin
                  state_r <= S_EXEC;
               end else begin
                  state_r   <= S_FETCH;
                  illegal_r <= 1'b1;
               end
            end
            S_EXEC: begin
               case (opcode_r)
                  OP_R, OP_I:   state_r <= S_WB;
                  OP_LD, OP_ST: state_r <= S_MEM;
                  default:      state_r <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (bus.mem_ready_i) begin
                  state_r <= (opcode_r == OP_ST) ? S_FETCH : S_WB;
               end
            end
            S_WB:    state_r <= S_FETCH;
            default: state_r <= S_FETCH;
         endcase
      end
   end

   // Retirement happens at branch/jump EXEC, store completion and every WB.
   always_comb begin
      retire_s = 1'b0;
      case (state_r)
         S_EXEC:  retire_s = (opcode_r == OP_BR) || (opcode_r == OP_JAL) || (opcode_r == OP_JALR);
         S_MEM:   retire_s = bus.mem_ready_i && (opcode_r == OP_ST);
         S_WB:    retire_s = 1'b1;
         default: retire_s = 1'b0;
      endcase
   end

   // Per-state control outputs from registered state and latched decode.
   always_comb begin
      mem_req_s = 1'b0;
      mem_we_s  = 1'b0;
      iord_s    = 1'b0;
      ir_we_s   = 1'b0;
      pc_we_s   = 1'b0;
      pc_src_s  = 2'b00;
      reg_we_s  = 1'b0;
      wb_sel_s  = 2'b00;
      alu_op_s  = ALU_ADD;
      shift_s   = 2'b00;
      if (!rst_hold_r) begin
         case (state_r)
            S_FETCH: begin
               mem_req_s = 1'b1;
               ir_we_s   = bus.mem_ready_i;
               pc_we_s   = bus.mem_ready_i;
            end
            S_EXEC: begin
               alu_op_s = alu_decode(opcode_r, funct3_r, funct7_r);
               shift_s  = shift_decode(opcode_r, funct3_r);
               case (opcode_r)
                  OP_BR: begin
                     pc_we_s  = bus.branch_taken_i;
                     pc_src_s = {1'b0, bus.branch_taken_i};
                  end
                  OP_JAL: begin
                     pc_we_s  = 1'b1;
                     pc_src_s = 2'b01;
                     reg_we_s = 1'b1;
                     wb_sel_s = 2'b10;
                  end
                  OP_JALR: begin
                     pc_we_s  = 1'b1;
                     pc_src_s = 2'b10;
                     reg_we_s = 1'b1;
                     wb_sel_s = 2'b10;
                  end
                  default: pc_we_s = 1'b0;
               endcase
            end
            S_MEM: begin
               mem_req_s = 1'b1;
               iord_s    = 1'b1;
               mem_we_s  = (opcode_r == OP_ST);
               alu_op_s  = alu_decode(opcode_r, funct3_r, funct7_r);
            end
            S_WB: begin
               reg_we_s = 1'b1;
               wb_sel_s = (opcode_r == OP_LD) ? 2'b01 : 2'b00;
               alu_op_s = alu_decode(opcode_r, funct3_r, funct7_r);
               shift_s  = shift_decode(opcode_r, funct3_r);
            end
            default: mem_req_s = 1'b0;
         endcase
      end else begin
         mem_req_s = 1'b0;
      end
   end

   assign bus.mem_req_o = mem_req_s;
   assign bus.mem_we_o  = mem_we_s;
   assign bus.iord_o    = iord_s;
   assign bus.ir_we_o   = ir_we_s;
   assign bus.pc_we_o   = pc_we_s;
   assign bus.pc_src_o  = pc_src_s;
   assign bus.reg_we_o  = reg_we_s;
   assign bus.wb_sel_o  = wb_sel_s;
   assign bus.alu_op_o  = alu_op_s;
   assign bus.shift_o   = shift_s;
   assign bus.illegal_o = illegal_r;
   assign bus.state_o   = state_r;
   assign bus.retired_o = retired_r;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl. A reference model expands
// each instruction into its expected per-cycle observation; a monitor pops
// and compares one observation per cycle on the falling edge.
module tb_multicycle_ctrl;
   localparam int RW = 4;   // narrow counter so wrap-around is exercised

   typedef struct packed {
      logic [2:0]    state;
      logic          mem_req;
      logic          mem_we;
      logic          iord;
      logic          ir_we;
      logic          pc_we;
      logic [1:0]    pc_src;
      logic          reg_we;
      logic [1:0]    wb_sel;
      logic [3:0]    alu_op;
      logic [1:0]    shift;
      logic          illegal;
      logic [RW-1:0] retired;
   } obs_t;

   typedef enum int {K_ALU, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

   logic clk;
   logic rst_n;
   multicycle_ctrl_if #(.RETIRE_W(RW)) bus ();

   multicycle_ctrl #(.RETIRE_W(RW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   obs_t        exp_q[$];
   bit          chk_q[$];
   int          n_total = 0;
   int          n_pass  = 0;
   int          cyc_no  = 0;
   logic [RW-1:0] cnt = '0;
   logic        pend_ill = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic rbit();
      return ($urandom_range(0, 1) == 1);
   endfunction

   function automatic obs_t idle_obs(input logic [2:0] st);
      obs_t e;
      e = '0;
      e.state   = st;
      e.alu_op  = 4'b0010;
      e.retired = cnt;
      return e;
   endfunction

   // Instruction classification straight from the ISA subset rules.
   function automatic void classify(input logic [31:0] ins, output kind_t k,
                                    output logic [3:0] alu, output logic [1:0] sh);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      k = K_ILL;
      alu = 4'b0010;
      sh = 2'b00;
      if (op == 7'h33) begin
         if (f7 == 7'h20) begin k = K_ALU; alu = 4'b0110; end
         else if (f7 == 7'h00 && f3 == 3'b000) begin k = K_ALU; alu = 4'b0010; end
         else if (f7 == 7'h00 && f3 == 3'b111) begin k = K_ALU; alu = 4'b0000; end
         else if (f7 == 7'h00 && f3 == 3'b110) begin k = K_ALU; alu = 4'b0001; end
      end else if (op == 7'h13) begin
         k = K_ALU;
         if (f3 == 3'b001) sh = 2'b11;
         else if (f3 == 3'b101) sh = 2'b10;
      end else if (op == 7'h03) k = K_LD;
      else if (op == 7'h23) k = K_ST;
      else if (op == 7'h63) begin k = K_BR; alu = 4'b0110; end
      else if (op == 7'h6F) k = K_JAL;
      else if (op == 7'h67) k = K_JALR;
   endfunction

   function automatic logic [RW-1:0] inc(input logic [RW-1:0] v);
      return RW'((int'(v) + 1) % (1 << RW));
   endfunction

   // One clock: drive inputs after the edge, queue what that cycle must show.
   task automatic cyc(input logic rn, input logic rdy, input logic tk, input logic [31:0] ins,
                      input obs_t e, input bit chk, input bit push);
      @(posedge clk);
      #1;
      rst_n              = rn;
      bus.mem_ready_i    = rdy;
      bus.branch_taken_i = tk;
      bus.instr_i        = ins;
      if (push) begin
         exp_q.push_back(e);
         chk_q.push_back(chk);
      end
   endtask

   task automatic hold_after_reset();
      obs_t e;
      cnt      = '0;
      pend_ill = 1'b0;
      e = idle_obs(3'd0);
      cyc(1'b1, 1'b0, rbit(), $urandom, e, 1'b1, 1'b1);
   endtask

   // Reference model: expand one instruction into expected cycles.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic tk, input int rst_at);
      obs_t e;
      kind_t k;
      logic [3:0] alu;
      logic [1:0] sh;
      classify(ins, k, alu, sh);
      for (int i = 0; i <= fw; i++) begin
         e = idle_obs(3'd0);
         e.mem_req = 1'b1;
         e.ir_we   = (i == fw);
         e.pc_we   = (i == fw);
         e.illegal = pend_ill;
         pend_ill  = 1'b0;
         cyc(1'b1, (i == fw), rbit(), $urandom, e, 1'b1, 1'b1);
      end
      e = idle_obs(3'd1);
      cyc(1'b1, rbit(), rbit(), ins, e, 1'b0, 1'b1);
      if (k == K_ILL) begin
         pend_ill = 1'b1;
         return;
      end
      e = idle_obs(3'd2);
      e.alu_op = alu;
      e.shift  = sh;
      if (k == K_BR) begin
         e.pc_we  = tk;
         e.pc_src = tk ? 2'b01 : 2'b00;
      end else if (k == K_JAL || k == K_JALR) begin
         e.pc_we  = 1'b1;
         e.pc_src = (k == K_JAL) ? 2'b01 : 2'b10;
         e.reg_we = 1'b1;
         e.wb_sel = 2'b10;
      end
      cyc(1'b1, rbit(), tk, ins, e, (k != K_JAL), 1'b1);
      if (k == K_BR || k == K_JAL || k == K_JALR) begin
         cnt = inc(cnt);
         return;
      end
      if (k == K_LD || k == K_ST) begin
         for (int i = 0; i <= mw; i++) begin
            e = idle_obs(3'd3);
            e.mem_req = 1'b1;
            e.iord    = 1'b1;
            e.mem_we  = (k == K_ST);
            if (i == rst_at) begin
               cyc(1'b0, 1'b0, rbit(), ins, e, 1'b0, 1'b1);
               hold_after_reset();
               return;
            end
            cyc(1'b1, (i == mw), rbit(), ins, e, 1'b0, 1'b1);
         end
         if (k == K_ST) begin
            cnt = inc(cnt);
            return;
         end
      end
      e = idle_obs(3'd4);
      e.reg_we = 1'b1;
      e.wb_sel = (k == K_LD) ? 2'b01 : 2'b00;
      cyc(1'b1, rbit(), rbit(), ins, e, 1'b0, 1'b1);
      cnt = inc(cnt);
   endtask

   // Monitor: compare every queued observation on the falling edge.
   initial begin
      obs_t e;
      obs_t act;
      bit   c;
      forever begin
         @(negedge clk);
         cyc_no++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            act.state   = bus.state_o;
            act.mem_req = bus.mem_req_o;
            act.mem_we  = bus.mem_we_o;
            act.iord    = bus.iord_o;
            act.ir_we   = bus.ir_we_o;
            act.pc_we   = bus.pc_we_o;
            act.pc_src  = bus.pc_src_o;
            act.reg_we  = bus.reg_we_o;
            act.wb_sel  = bus.wb_sel_o;
            act.alu_op  = c ? bus.alu_op_o : e.alu_op;
            act.shift   = c ? bus.shift_o  : e.shift;
            act.illegal = bus.illegal_o;
            act.retired = bus.retired_o;
            n_total++;
            if (act === e) begin
               n_pass++;
            end else begin
               $display("FAIL cycle_obs @%0d: actual st=%0d req=%b we=%b iord=%b ir=%b pcwe=%b pcsrc=%b rwe=%b wb=%b alu=%b sh=%b ill=%b ret=%0d | required st=%0d req=%b we=%b iord=%b ir=%b pcwe=%b pcsrc=%b rwe=%b wb=%b alu=%b sh=%b ill=%b ret=%0d",
                        cyc_no, act.state, act.mem_req, act.mem_we, act.iord, act.ir_we, act.pc_we,
                        act.pc_src, act.reg_we, act.wb_sel, act.alu_op, act.shift, act.illegal, act.retired,
                        e.state, e.mem_req, e.mem_we, e.iord, e.ir_we, e.pc_we,
                        e.pc_src, e.reg_we, e.wb_sel, e.alu_op, e.shift, e.illegal, e.retired);
            end
         end
      end
   end

   // Stimulus: directed cases first, then randomized instruction stream.
   initial begin
      logic [6:0]  ops[10];
      logic [31:0] ins;
      logic [6:0]  f7;
      obs_t        e;
      int          fw;
      int          mw;
      int          ra;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h00, 7'h0B};
      rst_n              = 1'b0;
      bus.instr_i        = 32'd0;
      bus.mem_ready_i    = 1'b0;
      bus.branch_taken_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 32'd0, idle_obs(3'd0), 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, idle_obs(3'd0), 1'b0, 1'b0);
      hold_after_reset();

      run_instr(32'h002081B3, 0, 0, 1'b0, -1);   // add
      run_instr(32'h0000A283, 1, 3, 1'b0, -1);   // lw, 3-cycle memory wait
      run_instr(32'h0050A223, 0, 1, 1'b0, -1);   // sw
      run_instr(32'h00000463, 0, 0, 1'b1, -1);   // beq taken
      run_instr(32'h00000463, 2, 0, 1'b0, -1);   // beq not taken
      run_instr(32'h0000007F, 0, 0, 1'b0, -1);   // illegal opcode
      run_instr(32'h0020F1B3, 0, 0, 1'b0, -1);   // and
      run_instr(32'h0020E1B3, 0, 0, 1'b0, -1);   // or
      run_instr(32'h402081B3, 0, 0, 1'b0, -1);   // sub
      run_instr(32'h00209193, 0, 0, 1'b0, -1);   // slli
      run_instr(32'h0020D193, 0, 0, 1'b0, -1);   // srli
      run_instr(32'h0000A283, 0, 5, 1'b0, 2);    // lw aborted by reset while waiting
      run_instr(32'h008000EF, 0, 0, 1'b0, -1);   // jal
      run_instr(32'h000080E7, 0, 0, 1'b0, -1);   // jalr

      for (int n = 0; n < 160; n++) begin
         ins = $urandom;
         ins[6:0] = ops[$urandom_range(0, 9)];
         case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         ins[31:25] = f7;
         fw = $urandom_range(0, 3);
         mw = $urandom_range(0, 3);
         ra = ($urandom_range(0, 14) == 0) ? $urandom_range(0, mw) : -1;
         run_instr(ins, fw, mw, rbit(), ra);
      end

      e = idle_obs(3'd0);
      e.mem_req = 1'b1;
      e.illegal = pend_ill;
      cyc(1'b1, 1'b0, 1'b0, 32'd0, e, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      n_total++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n_i  in  1  reset; synchronous, active-low.
REQ-004 instr_i  in  32  instruction register contents, valid from DECODE onward.
REQ-005 mem_ready_i  in  1  memory acknowledge for the current request.
REQ-006 branch_taken_i  in  1  datapath compare result, valid in EXEC.
REQ-007 mem_req_o  out  1  memory request, held until acknowledged.
REQ-008 mem_we_o  out  1  memory write enable, qualifies mem_req_o.
REQ-009 iord_o  out  1  address select: 0 = PC, 1 = ALU result.
REQ-010 ir_we_o  out  1  instruction register load strobe.
REQ-011 pc_we_o  out  1  PC load strobe.
REQ-012 pc_src_o  out  2  PC source: 00 = PC+4, 01 = branch/jal target, 10 = ALU result (jalr).
REQ-013 reg_we_o  out  1  register-file write strobe.
REQ-014 wb_sel_o  out  2  write-back source: 00 = ALU, 01 = memory data, 10 = link (PC+4).
REQ-015 alu_op_o  out  4  ALU control: 0010 add, 0110 sub, 0000 and, 0001 or.
REQ-016 shift_o  out  2  shift control: 11 = sll, 10 = srl, 00 = none.
REQ-017 illegal_o  out  1  one-cycle pulse on an unsupported instruction.
REQ-018 state_o  out  3  current state: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
REQ-019 retired_o  out  RETIRE_W  count of completed instructions.

Function
REQ-020 All strobes (mem_req_o, mem_we_o, ir_we_o, pc_we_o, reg_we_o, illegal_o) shall be Moore outputs of the current state and latched decode, with no combinational path from instr_i to a strobe.
REQ-021 FETCH: mem_req_o = 1 and iord_o = 0 until mem_ready_i; in the cycle mem_ready_i = 1, ir_we_o = 1, pc_we_o = 1 and pc_src_o = 00; next state is DECODE.
REQ-022 DECODE: one cycle; latch opcode, funct3 and funct7; next state is EXEC, or FETCH with illegal_o = 1 if the opcode is not one of 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67.
REQ-023 Opcode 0x33 with funct7 = 0x20 shall give alu_op_o = 0110.
REQ-024 Opcode 0x33 with funct7 = 0x00 shall map funct3 000, 111 and 110 to alu_op_o 0010, 0000 and 0001; any other funct3 is illegal (handled as in REQ-022).
REQ-025 Opcodes 0x13, 0x03, 0x23 and 0x67 shall give alu_op_o = 0010; opcode 0x63 shall give alu_op_o = 0110.
REQ-026 For opcode 0x13, shift_o shall be 11 for funct3 = 001, 10 for funct3 = 101, and 00 otherwise.
REQ-027 EXEC, opcodes 0x33 and 0x13: next state is WB.
REQ-028 EXEC, opcodes 0x03 and 0x23: next state is MEM.
REQ-029 EXEC, opcode 0x63: if branch_taken_i = 1, pc_we_o = 1 and pc_src_o = 01; next state is FETCH and the instruction retires.
REQ-030 EXEC, opcodes 0x6F and 0x67: pc_we_o = 1, pc_src_o = 01 (0x6F) or 10 (0x67), reg_we_o = 1 and wb_sel_o = 10; next state is FETCH and the instruction retires.
REQ-031 MEM: mem_req_o = 1, iord_o = 1, and mem_we_o = 1 for a store, held stable until mem_ready_i; on ready, a store goes to FETCH and retires, and a load goes to WB.
REQ-032 WB: one cycle; reg_we_o = 1 with wb_sel_o = 01 for a load and 00 otherwise; next state is FETCH and the instruction retires.
REQ-033 retired_o shall increment by 1 in the cycle of each retirement, wrap modulo 2^RETIRE_W, and not count illegal instructions.
REQ-034 Memory wait has no timeout; the FSM stalls indefinitely with request outputs unchanged.
REQ-035 When idle, outputs shall be: alu_op_o = 0010, pc_src_o = 00, wb_sel_o = 00, shift_o = 00, iord_o = 0.

Reset
REQ-036 While rst_n_i = 0 at a clock edge: state goes to FETCH, retired_o goes to 0, and all strobes are 0 in the following cycle.
REQ-037 Reset mid-operation, including during an outstanding memory request, shall abort the instruction without retiring it; mem_req_o drops the cycle after reset and reasserts in FETCH once rst_n_i = 1.

Verification
REQ-038 Stimulus: instruction 0x002081B3 (add), mem_ready_i = 1 in the first FETCH cycle. Response: states 0,1,2,4,0; alu_op_o = 0010; one reg_we_o pulse with wb_sel_o = 00; retired_o = 1.
REQ-039 Stimulus: instruction 0x0000A283 (lw), mem_ready_i delayed 3 cycles in MEM. Response: mem_req_o = 1 with iord_o = 1 and mem_we_o = 0 held 4 cycles; then WB with wb_sel_o = 01.
REQ-040 Stimulus: instruction 0x0050A223 (sw). Response: mem_we_o = 1 in MEM; reg_we_o never asserted; return to FETCH after MEM.
REQ-041 Stimulus: instruction 0x00000463 (beq), run once with branch_taken_i = 1 and once with 0. Response: pc_we_o pulse with pc_src_o = 01 in EXEC only when taken; alu_op_o = 0110; retired_o increments in both cases.
REQ-042 Stimulus: instruction 0x0000007F. Response: illegal_o pulses for 1 cycle after DECODE; retired_o unchanged; next state FETCH.
REQ-043 Stimulus: rst_n_i = 0 for 1 cycle while in MEM waiting. Response: state_o = 0 and mem_req_o = 0 next cycle; retired_o = 0.
